// File: rtl/imm_extend_pipe_if.sv
// Handshake and data bundle for imm_extend_pipe: immediate input side,
// extended result output side and the delivered-result counter.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [IN_W-1:0]  data_i;
    logic [1:0]       mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] data_o;
    logic [7:0]       count_o;

    // The extender block is the slave; its environment is the master.
    modport slave (
        input  valid_i, data_i, mode_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );

    modport master (
        output valid_i, data_i, mode_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender with a two-entry in-order output buffer (head + skid).
// Results are extended on entry, so the buffer only ever holds OUT_W-bit values.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    imm_extend_pipe_if.slave   bus
);

    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

    localparam int PAD_W = OUT_W - IN_W;

    state_t           state, state_next;
    logic [OUT_W-1:0] head, head_next;
    logic [OUT_W-1:0] skid, skid_next;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] sext;
    logic [7:0]       count;
    logic             push, pop;

    // Handshake outputs decode registered state only, so ready_o never
    // depends combinationally on ready_i.
    assign bus.ready_o = (state != TWO);
    assign bus.valid_o = (state != EMPTY);
    assign bus.data_o  = head;
    assign bus.count_o = count;

    assign push = bus.valid_i & bus.ready_o;
    assign pop  = bus.valid_o & bus.ready_i;

    assign sext = {{PAD_W{bus.data_i[IN_W-1]}}, bus.data_i};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        ext = sext;
        unique case (mode_t'(bus.mode_i))
            MODE_SIGN:   ext = sext;
            MODE_ZERO:   ext = {{PAD_W{1'b0}}, bus.data_i};
            MODE_UPPER:  ext = {bus.data_i, {PAD_W{1'b0}}};
            MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
            default:     ext = sext;
        endcase
    end

    always_comb begin
        state_next = state;
        head_next  = head;
        skid_next  = skid;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    head_next  = ext;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_next = ext;
                end else if (push) begin
                    state_next = TWO;
                    skid_next  = ext;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // ready_o is low here, so only a pop can move the state.
                if (pop) begin
                    state_next = ONE;
                    head_next  = skid;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= EMPTY;
            // NOTE: both buffer words are cleared on reset so data_o reads 0
            // while idle after reset and no stale value can resurface.
            head  <= '0;
            skid  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            skid  <= skid_next;
            if (pop) begin
                count <= count + 8'd1;
            end
        end
    end

endmodule
